// File: rtl/spi_slave_param.sv
// SPI slave front-end: shifts in {cmd, payload} frames MSB first and, on a read-data command,
// waits (bounded) for a tx word and shifts it out on MISO. All outputs are registered.
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              abort,
  output logic              seq_err,
  output logic              timeout_err
);

  localparam int W  = DATA_W + 2;
  localparam int CW = $clog2(W + TX_TIMEOUT + 1) + 1;
  localparam logic [CW-1:0] RX_LAST = CW'(W - 1);
  localparam logic [CW-1:0] TX_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RX, TX_WAIT, TX, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [W-2:0]      shreg, shreg_n;
  logic [W-1:0]      frame, rx_data_n;
  logic [DATA_W-1:0] tx_sh, tx_sh_n;
  logic              rd_pending, rd_pending_n;
  logic              miso_n, rx_valid_n, abort_n, seq_err_n, timeout_err_n;

  // Frame including the bit being sampled this edge; cmd sits in the top two bits.
  assign frame = {shreg, MOSI};

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    shreg_n       = shreg;
    tx_sh_n       = tx_sh;
    rd_pending_n  = rd_pending;
    rx_data_n     = rx_data;
    miso_n        = 1'b0;
    rx_valid_n    = 1'b0;
    abort_n       = 1'b0;
    seq_err_n     = 1'b0;
    timeout_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (!SS_n) begin
          state_n = RX;
          cnt_n   = '0;
        end
      end
      RX: begin
        if (SS_n) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end else begin
          shreg_n = frame[W-2:0];
          cnt_n   = cnt + 1'b1;
          if (cnt == RX_LAST) begin
            state_n = DONE;
            case (frame[W-1:W-2])
              2'b11: begin
                if (rd_pending) begin
                  rx_data_n    = frame;
                  rx_valid_n   = 1'b1;
                  rd_pending_n = 1'b0;
                  state_n      = TX_WAIT;
                  cnt_n        = '0;
                end else begin
                  seq_err_n = 1'b1;
                end
              end
              2'b10: begin
                rx_data_n    = frame;
                rx_valid_n   = 1'b1;
                rd_pending_n = 1'b1;
              end
              default: begin
                rx_data_n  = frame;
                rx_valid_n = 1'b1;
              end
            endcase
          end
        end
      end
      TX_WAIT: begin
        if (SS_n) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end else if (tx_valid) begin
          miso_n  = tx_data[DATA_W-1];
          tx_sh_n = tx_data << 1;
          state_n = TX;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          timeout_err_n = 1'b1;
          state_n       = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX: begin
        if (SS_n) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end else if (cnt == TX_LAST) begin
          state_n = DONE;
        end else begin
          miso_n  = tx_sh[DATA_W-1];
          tx_sh_n = tx_sh << 1;
          cnt_n   = cnt + 1'b1;
        end
      end
      DONE: begin
        if (SS_n) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      tx_sh       <= '0;
      rd_pending  <= 1'b0;
      rx_data     <= '0;
      MISO        <= 1'b0;
      rx_valid    <= 1'b0;
      abort       <= 1'b0;
      seq_err     <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      tx_sh       <= tx_sh_n;
      rd_pending  <= rd_pending_n;
      rx_data     <= rx_data_n;
      MISO        <= miso_n;
      rx_valid    <= rx_valid_n;
      abort       <= abort_n;
      seq_err     <= seq_err_n;
      timeout_err <= timeout_err_n;
      busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboard bench for spi_slave_param: one DATA_W=8 and one DATA_W=16 instance, pulses checked
// by a negedge monitor against queued expectations, MISO and busy checked inline.
module tb_spi_slave_param;

  localparam int TO = 16;
  localparam int K_RXV = 0, K_ABORT = 1, K_SEQ = 2, K_TOUT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  logic        ss0, mosi0, txv0, miso0, rxv0, busy0, ab0, se0, to0;
  logic [7:0]  txd0;
  logic [9:0]  rxd0;
  logic        ss1, mosi1, txv1, miso1, rxv1, busy1, ab1, se1, to1;
  logic [15:0] txd1;
  logic [17:0] rxd1;

  spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(TO)) dut8 (
    .clk(clk), .rst(rst), .SS_n(ss0), .MOSI(mosi0), .tx_data(txd0), .tx_valid(txv0),
    .MISO(miso0), .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0), .abort(ab0),
    .seq_err(se0), .timeout_err(to0)
  );

  spi_slave_param #(.DATA_W(16), .TX_TIMEOUT(TO)) dut16 (
    .clk(clk), .rst(rst), .SS_n(ss1), .MOSI(mosi1), .tx_data(txd1), .tx_valid(txv1),
    .MISO(miso1), .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1), .abort(ab1),
    .seq_err(se1), .timeout_err(to1)
  );

  typedef struct {
    int          kind;
    logic [17:0] data;
    int unsigned at;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  checks = 0;
  int  passes = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int id, input int kind, input logic [17:0] data, input int unsigned at);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.at   = at;
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon(input int id, input logic rv, input logic ab, input logic se,
                     input logic tt, input logic [17:0] rd);
    int  n;
    int  k;
    ev_t e;
    n = int'(rv) + int'(ab) + int'(se) + int'(tt);
    if (n == 0) return;
    if (n > 1) begin
      checks++;
      $display("FAIL pulses_exclusive inst%0d: %0d pulses at cycle %0d, expected 1", id, n, cyc);
    end
    k = rv ? K_RXV : ab ? K_ABORT : se ? K_SEQ : K_TOUT;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      checks++;
      $display("FAIL unexpected_pulse inst%0d: kind %0d at cycle %0d, expected none", id, k, cyc);
      return;
    end
    if (id == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk("pulse_kind", k, e.kind);
    chk("pulse_cycle", cyc, e.at);
    if (e.kind == K_RXV) chk("rx_data", rd, e.data);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, rxv0, ab0, se0, to0, {8'b0, rxd0});
      mon(1, rxv1, ab1, se1, to1, rxd1);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ss(input int id, input logic v);
    if (id == 0) ss0 = v;
    else ss1 = v;
  endtask

  task automatic set_mosi(input int id, input logic v);
    if (id == 0) mosi0 = v;
    else mosi1 = v;
  endtask

  function automatic logic miso_of(input int id);
    return (id == 0) ? miso0 : miso1;
  endfunction

  // Leaves SS_n low; the DUT ends in DONE or TX_WAIT.
  task automatic send_frame(input int id, input logic [17:0] bits, input int nb,
                            input int kind, input logic [17:0] data);
    set_ss(id, 1'b0);
    tick;
    for (int i = 0; i < nb; i++) begin
      set_mosi(id, bits[nb-1-i]);
      if (i == nb - 1 && kind >= 0) push(id, kind, data, cyc + 1);
      tick;
    end
    set_mosi(id, 1'b0);
  endtask

  task automatic end_frame(input int id);
    set_ss(id, 1'b1);
    tick;
  endtask

  task automatic tx_word(input int id, input logic [15:0] w, input int nb);
    if (id == 0) begin txd0 = w[7:0]; txv0 = 1'b1; end
    else begin txd1 = w; txv1 = 1'b1; end
    tick;
    txv0 = 1'b0;
    txv1 = 1'b0;
    for (int i = 0; i < nb; i++) begin
      chk("miso_bit", miso_of(id), w[nb-1-i]);
      tick;
    end
    chk("miso_after_tx", miso_of(id), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ss0 = 1'b1; mosi0 = 1'b0; txv0 = 1'b0; txd0 = '0;
    ss1 = 1'b1; mosi1 = 1'b0; txv1 = 1'b0; txd1 = '0;
    repeat (3) tick;
    chk("reset_outputs8", {miso0, rxd0, rxv0, busy0, ab0, se0, to0}, 0);
    chk("reset_outputs16", {miso1, rxd1, rxv1, busy1, ab1, se1, to1}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick;

    // T4: read-data command with no pending address
    send_frame(0, 18'h3FF, 10, K_SEQ, '0);
    chk("t4_miso", miso0, 0);
    tick;
    chk("t4_miso_later", miso0, 0);
    chk("t4_rx_data_kept", rxd0, 0);
    end_frame(0);

    // T1: write frame
    send_frame(0, 18'h0A5, 10, K_RXV, 18'h0A5);
    chk("t1_busy_done", busy0, 1);
    tick;
    chk("t1_busy_hold", busy0, 1);
    end_frame(0);
    chk("t1_busy_idle", busy0, 0);

    // T2: read address then read data
    send_frame(0, 18'h210, 10, K_RXV, 18'h210);
    end_frame(0);
    send_frame(0, 18'h3FF, 10, K_RXV, 18'h3FF);
    repeat (3) tick;
    chk("t2_miso_wait", miso0, 0);
    tx_word(0, 16'h003C, 8);
    end_frame(0);

    // T3: abort after five bits, then a clean frame
    set_ss(0, 1'b0);
    tick;
    for (int i = 0; i < 5; i++) begin
      set_mosi(0, 1'b1);
      tick;
    end
    set_ss(0, 1'b1);
    push(0, K_ABORT, '0, cyc + 1);
    tick;
    chk("t3_rx_data_kept", rxd0, 10'h3FF);
    chk("t3_busy", busy0, 0);
    send_frame(0, 18'h1C3, 10, K_RXV, 18'h1C3);
    end_frame(0);

    // T5: timeout in TX_WAIT, then read pending is gone
    send_frame(0, 18'h2AB, 10, K_RXV, 18'h2AB);
    end_frame(0);
    send_frame(0, 18'h300, 10, K_RXV, 18'h300);
    push(0, K_TOUT, '0, cyc + TO);
    repeat (TO) begin
      chk("t5_miso_wait", miso0, 0);
      tick;
    end
    tick;
    chk("t5_busy_done", busy0, 1);
    end_frame(0);
    send_frame(0, 18'h3FF, 10, K_SEQ, '0);
    end_frame(0);

    // T6: reset mid-TX
    send_frame(0, 18'h200, 10, K_RXV, 18'h200);
    end_frame(0);
    send_frame(0, 18'h3FF, 10, K_RXV, 18'h3FF);
    txd0 = 8'hA5;
    txv0 = 1'b1;
    tick;
    txv0 = 1'b0;
    repeat (2) tick;
    rst = 1'b1;
    ss0 = 1'b1;
    tick;
    chk("t6_reset_outputs", {miso0, rxd0, rxv0, busy0, ab0, se0, to0}, 0);
    rst = 1'b0;
    tick;
    chk("t6_after_reset", {miso0, rxd0, rxv0, busy0, ab0, se0, to0}, 0);
    send_frame(0, 18'h001, 10, K_RXV, 18'h001);
    end_frame(0);

    // DATA_W=16 instance: write, then read sequence
    send_frame(1, 18'h0A5C3, 18, K_RXV, 18'h0A5C3);
    chk("w16_busy_done", busy1, 1);
    end_frame(1);
    chk("w16_busy_idle", busy1, 0);
    send_frame(1, 18'h21234, 18, K_RXV, 18'h21234);
    end_frame(1);
    send_frame(1, 18'h3FFFF, 18, K_RXV, 18'h3FFFF);
    repeat (3) tick;
    tx_word(1, 16'hBEEF, 16);
    end_frame(1);

    repeat (4) tick;
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
